// File: rtl/cache_refill_ctrl.sv
// Miss-side refill controller for the 2-way set-associative data cache.
// Optional perf counters (miss_count, refill_cycles) enabled by REFILL_PERF_CNT_EN.
module cache_refill_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cache_hit,
  output logic                  stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data
`ifdef REFILL_PERF_CNT_EN
  ,
  output logic [31:0]           miss_count,
  output logic [31:0]           refill_cycles
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StFill,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
  logic [DATA_WIDTH-1:0]   fill_data_q, fill_data_d;
  logic                    miss_detect;

  assign miss_detect = (state_q == StIdle) && cpu_req_valid && !cache_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      miss_addr_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      fill_data_q <= fill_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    fill_data_d   = fill_data_q;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    fill_we       = 1'b0;
    fill_addr     = '0;
    unique case (state_q)
      StIdle: begin
        if (miss_detect) begin
          // Word-align: the cache fills whole words only.
          miss_addr_d = cpu_addr & ~ADDR_WIDTH'(3);
          stall       = 1'b1;
          state_d     = StReq;
        end
      end
      StReq: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_addr      = miss_addr_q;
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          fill_data_d = mem_rdata;
          state_d     = StFill;
        end
      end
      StFill: begin
        stall     = 1'b1;
        fill_we   = 1'b1;
        fill_addr = miss_addr_q;
        state_d   = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign fill_data = fill_data_q;

`ifdef REFILL_PERF_CNT_EN
  logic [31:0] miss_count_q, refill_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count_q    <= '0;
      refill_cycles_q <= '0;
    end else begin
      if (miss_detect) miss_count_q <= miss_count_q + 32'd1;
      if (stall)       refill_cycles_q <= refill_cycles_q + 32'd1;
    end
  end

  assign miss_count    = miss_count_q;
  assign refill_cycles = refill_cycles_q;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus pushes expected memory requests and cache
// fills into queues; a negedge monitor pops and compares them as the DUT presents them.
module tb_cache_refill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cpu_req_valid;
  logic [31:0] cpu_addr;
  logic        cache_hit;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic [31:0] fill_addr;
  logic [31:0] fill_data;
`ifdef REFILL_PERF_CNT_EN
  logic [31:0] miss_count;
  logic [31:0] refill_cycles;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] req_q[$];
  logic [31:0] fill_addr_q[$];
  logic [31:0] fill_data_q[$];

  cache_refill_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_addr      (cpu_addr),
    .cache_hit     (cache_hit),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata),
    .fill_we       (fill_we),
    .fill_addr     (fill_addr),
    .fill_data     (fill_data)
`ifdef REFILL_PERF_CNT_EN
    ,
    .miss_count    (miss_count),
    .refill_cycles (refill_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted request and every fill write must match the next queued entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_req_valid && mem_req_ready) begin
        if (req_q.size() == 0) chk("unexpected_req", mem_addr, 32'hFFFF_FFFF);
        else chk("req_addr", mem_addr, req_q.pop_front());
      end
      if (fill_we) begin
        if (fill_addr_q.size() == 0) chk("unexpected_fill", fill_addr, 32'hFFFF_FFFF);
        else begin
          chk("fill_addr", fill_addr, fill_addr_q.pop_front());
          chk("fill_data", fill_data, fill_data_q.pop_front());
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Minimum-latency miss: cycles 0..4, returns at the start of the following IDLE cycle.
  task automatic min_miss(input logic [31:0] addr, input logic [31:0] aligned,
                          input logic [31:0] data);
    req_q.push_back(aligned);
    fill_addr_q.push_back(aligned);
    fill_data_q.push_back(data);
    cpu_req_valid = 1'b1; cache_hit = 1'b0; cpu_addr = addr; mem_req_ready = 1'b1;
    @(negedge clk);
    chk("mm_c0_stall", 32'(stall), 32'd1);
    next_cycle();
    cpu_req_valid = 1'b0; cache_hit = 1'b1;
    @(negedge clk);
    chk("mm_c1_stall", 32'(stall), 32'd1);
    chk("mm_c1_mem_req_valid", 32'(mem_req_valid), 32'd1);
    chk("mm_c1_mem_addr", mem_addr, aligned);
    next_cycle();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = data;
    @(negedge clk);
    chk("mm_c2_stall", 32'(stall), 32'd1);
    chk("mm_c2_mem_req_valid", 32'(mem_req_valid), 32'd0);
    next_cycle();
    mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    chk("mm_c3_stall", 32'(stall), 32'd1);
    chk("mm_c3_fill_we", 32'(fill_we), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("mm_c4_stall", 32'(stall), 32'd0);
    chk("mm_c4_fill_we", 32'(fill_we), 32'd0);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req_valid = 1'b0; cpu_addr = 32'h0; cache_hit = 1'b1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    #2;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_fill_we", 32'(fill_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_fill_addr", fill_addr, 32'h0);
    chk("rst_fill_data", fill_data, 32'h0);
`ifdef REFILL_PERF_CNT_EN
    chk("rst_miss_count", miss_count, 32'h0);
    chk("rst_refill_cycles", refill_cycles, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hit path
    cpu_req_valid = 1'b1; cache_hit = 1'b1; cpu_addr = 32'h100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hit_stall", 32'(stall), 32'd0);
      chk("hit_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("hit_fill_we", 32'(fill_we), 32'd0);
      next_cycle();
    end
    cpu_req_valid = 1'b0;

    // Basic miss
    min_miss(32'h0000_1236, 32'h0000_1234, 32'hDEAD_BEEF);

    // Backpressure: 6 REQ cycles, response 3 cycles after accept
    req_q.push_back(32'h0000_4448);
    fill_addr_q.push_back(32'h0000_4448);
    fill_data_q.push_back(32'hCAFE_F00D);
    cpu_req_valid = 1'b1; cache_hit = 1'b0; cpu_addr = 32'h0000_444B; mem_req_ready = 1'b0;
    @(negedge clk);
    chk("bp_c0_stall", 32'(stall), 32'd1);
    next_cycle();
    cpu_req_valid = 1'b0; cache_hit = 1'b1; cpu_addr = 32'h0000_9990;
    for (int i = 0; i < 6; i++) begin
      mem_req_ready = (i == 5);
      @(negedge clk);
      chk("bp_req_valid", 32'(mem_req_valid), 32'd1);
      chk("bp_req_addr", mem_addr, 32'h0000_4448);
      chk("bp_req_stall", 32'(stall), 32'd1);
      next_cycle();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = (i == 2);
      mem_rdata = (i == 2) ? 32'hCAFE_F00D : 32'h0;
      @(negedge clk);
      chk("bp_wait_stall", 32'(stall), 32'd1);
      chk("bp_wait_fill_we", 32'(fill_we), 32'd0);
      next_cycle();
    end
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("bp_fill_we", 32'(fill_we), 32'd1);
    chk("bp_fill_stall", 32'(stall), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("bp_done_stall", 32'(stall), 32'd0);
    next_cycle();

    // Spurious responses in IDLE and in REQ
    mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("sp_idle_stall", 32'(stall), 32'd0);
    chk("sp_idle_fill_we", 32'(fill_we), 32'd0);
    next_cycle();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("sp_idle2_fill_we", 32'(fill_we), 32'd0);
    chk("sp_idle2_req_valid", 32'(mem_req_valid), 32'd0);
    next_cycle();
    req_q.push_back(32'h0000_0800);
    fill_addr_q.push_back(32'h0000_0800);
    fill_data_q.push_back(32'h1234_5678);
    cpu_req_valid = 1'b1; cache_hit = 1'b0; cpu_addr = 32'h0000_0801;
    next_cycle();
    cpu_req_valid = 1'b0; cache_hit = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0; mem_req_ready = 1'b0;
    next_cycle();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("sp_req_held", 32'(mem_req_valid), 32'd1);
    chk("sp_req_fill_we", 32'(fill_we), 32'd0);
    next_cycle();
    mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    next_cycle();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("sp_fill_we", 32'(fill_we), 32'd1);
    next_cycle();
    next_cycle();

    // Reset during WAIT
    req_q.push_back(32'h0000_0C00);
    cpu_req_valid = 1'b1; cache_hit = 1'b0; cpu_addr = 32'h0000_0C02; mem_req_ready = 1'b1;
    next_cycle();
    cpu_req_valid = 1'b0; cache_hit = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("rw_in_wait_stall", 32'(stall), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rw_fill_we", 32'(fill_we), 32'd0);
    chk("rw_mem_addr", mem_addr, 32'h0);
    chk("rw_fill_addr", fill_addr, 32'h0);
    chk("rw_fill_data", fill_data, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rw_resp_stall", 32'(stall), 32'd0);
    chk("rw_resp_fill_we", 32'(fill_we), 32'd0);
    next_cycle();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("rw_after_fill_we", 32'(fill_we), 32'd0);
    chk("rw_after_stall", 32'(stall), 32'd0);
    next_cycle();

`ifdef REFILL_PERF_CNT_EN
    // Counters: two back-to-back minimum-latency misses after reset
    chk("cnt_miss_zero", miss_count, 32'd0);
    chk("cnt_cycles_zero", refill_cycles, 32'd0);
    min_miss(32'h0000_2000, 32'h0000_2000, 32'h0101_0101);
    min_miss(32'h0000_3007, 32'h0000_3004, 32'h0202_0202);
    chk("cnt_miss_count", miss_count, 32'd2);
    chk("cnt_refill_cycles", refill_cycles, 32'd8);
`endif

    repeat (3) next_cycle();
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("fill_q_empty", 32'(fill_addr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
